hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It drives the hold/flush controls of the IF/ID pipeline register, the PC write enable and the ID/EX bubble insertion. It resolves three hazards:
- load-use hazards
- structural hazards on the multi-cycle multiply/divide unit (MDU)
- control hazards from taken branches and jumps

It sits beside the ID stage and also exports a saturating stall-cycle counter for performance measurement.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/hazard_stall_ctrl_mdu_busy_timer.sv | 29 ++
 rtl/hazard_stall_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard controller state encoding and the
// constants used by the IF/ID and ID/EX pipeline registers.
package pipeline_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hazard_state_t;

    // Register $zero never carries a real dependency
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    // Encoding loaded into IF/ID on a flush
    localparam logic [31:0] NOP       = 32'h0000_0000;

    // Width of the MDU countdown; MDU latencies up to 15 fit
    localparam int          MDU_CNT_W = 4;

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_timer.sv
// Loadable down-counter tracking how many more cycles the multi-cycle
// multiply/divide unit stays occupied. Busy whenever the count is nonzero.
module mdu_busy_timer
    import pipeline_pkg::*;
#(
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    // Load on issue, otherwise count down to zero and stay there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller sitting beside the ID stage. Resolves load-use,
// MDU structural and branch/jump control hazards, and counts stall cycles.
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 4,
    parameter int PERF_W      = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRt,
    input  logic                  ID_IsMulDiv,
    input  logic                  ID_ReadsHiLo,
    input  logic                  ID_Jump,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_Rt,
    input  logic                  EX_BranchTaken,
    output logic                  PCWrite,
    output logic                  IF_ID_Stall,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Bubble,
    output logic                  MDU_Busy,
    output logic [PERF_W-1:0]     StallCycles
);

    hazard_state_t          state;
    hazard_state_t          next_state;
    logic [MDU_CNT_W-1:0]   mdu_cnt;
    logic                   mdu_issue;
    logic                   load_use;
    logic                   mdu_hz;

    assign load_use = EX_MemRead
                    && (EX_Rt != REG_ADDR_W'(REG_ZERO))
                    && ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    assign mdu_hz = (state == MDU_BUSY) && (ID_IsMulDiv || ID_ReadsHiLo);

    mdu_busy_timer #(
        .CNT_W      (MDU_CNT_W)
    ) u_mdu_timer (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .load       (mdu_issue),
        .load_value (MDU_CNT_W'(MDU_LATENCY)),
        .count      (mdu_cnt),
        .busy       (MDU_Busy)
    );

    // State register for the MDU occupancy FSM
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Prioritised pipeline controls and next-state; flush beats stall beats jump
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Stall  = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        mdu_issue    = 1'b0;
        next_state   = state;

        if (!Reset_n) begin
            PCWrite      = 1'b0;
            IF_ID_Stall  = 1'b1;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (load_use || mdu_hz) begin
            PCWrite      = 1'b0;
            IF_ID_Stall  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else begin
            IF_ID_Flush  = ID_Jump;
            mdu_issue    = ID_IsMulDiv;
        end

        case (state)
            RUN: begin
                if (mdu_issue) begin
                    next_state = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                if (mdu_cnt <= MDU_CNT_W'(1)) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // Saturating count of cycles the front end was held
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            StallCycles <= '0;
        end else if (IF_ID_Stall && (StallCycles != '1)) begin
            StallCycles <= StallCycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl. A second instance with a 4-bit
// stall counter shares the same stimulus to exercise counter saturation.
module tb_hazard_stall_ctrl;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRt;
    logic        ID_IsMulDiv;
    logic        ID_ReadsHiLo;
    logic        ID_Jump;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        EX_BranchTaken;

    logic        PCWrite, IF_ID_Stall, IF_ID_Flush, ID_EX_Bubble, MDU_Busy;
    logic [15:0] StallCycles;
    logic        sat_PCWrite, sat_IF_ID_Stall, sat_IF_ID_Flush, sat_ID_EX_Bubble, sat_MDU_Busy;
    logic [3:0]  sat_StallCycles;

    int pass_count  = 0;
    int fail_count  = 0;
    int check_count = 0;
    int exp_stalls  = 0;

    always #5 Clock = ~Clock;

    hazard_stall_ctrl #(
        .REG_ADDR_W  (5),
        .MDU_LATENCY (4),
        .PERF_W      (16)
    ) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_IsMulDiv    (ID_IsMulDiv),
        .ID_ReadsHiLo   (ID_ReadsHiLo),
        .ID_Jump        (ID_Jump),
        .EX_MemRead     (EX_MemRead),
        .EX_Rt          (EX_Rt),
        .EX_BranchTaken (EX_BranchTaken),
        .PCWrite        (PCWrite),
        .IF_ID_Stall    (IF_ID_Stall),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .MDU_Busy       (MDU_Busy),
        .StallCycles    (StallCycles)
    );

    hazard_stall_ctrl #(
        .REG_ADDR_W  (5),
        .MDU_LATENCY (4),
        .PERF_W      (4)
    ) dut_sat (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_IsMulDiv    (ID_IsMulDiv),
        .ID_ReadsHiLo   (ID_ReadsHiLo),
        .ID_Jump        (ID_Jump),
        .EX_MemRead     (EX_MemRead),
        .EX_Rt          (EX_Rt),
        .EX_BranchTaken (EX_BranchTaken),
        .PCWrite        (sat_PCWrite),
        .IF_ID_Stall    (sat_IF_ID_Stall),
        .IF_ID_Flush    (sat_IF_ID_Flush),
        .ID_EX_Bubble   (sat_ID_EX_Bubble),
        .MDU_Busy       (sat_MDU_Busy),
        .StallCycles    (sat_StallCycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the combinational controls and busy flag right now
    task automatic check_ctrl_now(input string tag, input logic pc, input logic st,
                                  input logic fl, input logic bb, input logic busy);
        check({tag, ".PCWrite"},      {31'd0, PCWrite},      {31'd0, pc});
        check({tag, ".IF_ID_Stall"},  {31'd0, IF_ID_Stall},  {31'd0, st});
        check({tag, ".IF_ID_Flush"},  {31'd0, IF_ID_Flush},  {31'd0, fl});
        check({tag, ".ID_EX_Bubble"}, {31'd0, ID_EX_Bubble}, {31'd0, bb});
        check({tag, ".MDU_Busy"},     {31'd0, MDU_Busy},     {31'd0, busy});
    endtask

    task automatic check_counts(input string tag);
        int sat_exp;
        sat_exp = (exp_stalls > 15) ? 15 : exp_stalls;
        check({tag, ".StallCycles"},     {16'd0, StallCycles},     32'(exp_stalls));
        check({tag, ".StallCycles_sat"}, {28'd0, sat_StallCycles}, 32'(sat_exp));
    endtask

    // Mid-cycle sample; a cycle expected to stall bumps the expected count
    task automatic check_output(input string tag, input logic pc, input logic st,
                                input logic fl, input logic bb, input logic busy);
        @(negedge Clock);
        check_ctrl_now(tag, pc, st, fl, bb, busy);
        check_counts(tag);
        if (Reset_n && st) begin
            exp_stalls++;
        end
    endtask

    // Drive one cycle's worth of ID/EX inputs just after the rising edge
    task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic uses_rt, input logic muldiv,
                                  input logic hilo, input logic jump,
                                  input logic memread, input logic [4:0] ex_rt,
                                  input logic branch);
        @(posedge Clock);
        #1;
        ID_Rs          = rs;
        ID_Rt          = rt;
        ID_UsesRt      = uses_rt;
        ID_IsMulDiv    = muldiv;
        ID_ReadsHiLo   = hilo;
        ID_Jump        = jump;
        EX_MemRead     = memread;
        EX_Rt          = ex_rt;
        EX_BranchTaken = branch;
    endtask

    initial begin
        Reset_n        = 1'b0;
        ID_Rs          = '0;
        ID_Rt          = '0;
        ID_UsesRt      = 1'b0;
        ID_IsMulDiv    = 1'b0;
        ID_ReadsHiLo   = 1'b0;
        ID_Jump        = 1'b0;
        EX_MemRead     = 1'b0;
        EX_Rt          = '0;
        EX_BranchTaken = 1'b0;

        // Reset held: everything frozen and flushed
        check_output("reset_held", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge Clock);
        #1 Reset_n = 1'b1;
        check_output("run_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load-use on rs, then the load has left EX
        apply_stimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
        check_output("lu_rs", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check_output("lu_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load to $zero never stalls
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        check_output("lu_zero", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // rt dependency counts only when rt is a source
        apply_stimulus(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        check_output("lu_rt", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        check_output("lu_rt_unused", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Branch flush beats load-use and is not counted as a stall
        apply_stimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
        check_output("br_vs_lu", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check_output("br_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Jump under a load-use stall: stall first, flush next cycle
        apply_stimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
        check_output("jmp_stall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        check_output("jmp_flush", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // MDU issue followed by a dependent mflo held in ID
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check_output("mdu_issue", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
            check_output("mdu_wait", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        check_output("mflo_go", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // New countdown, branch flush during it, then reset two cycles in
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check_output("mdu_issue2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        check_output("flush_in_busy", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check_output("busy_2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #2 Reset_n = 1'b0;
        exp_stalls = 0;
        #1;
        check_ctrl_now("rst_mid", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_counts("rst_mid");
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        Reset_n = 1'b1;
        check_output("hilo_after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Twenty stall cycles: 16-bit counter reaches 20, 4-bit stops at 15
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
            check_output("sat_stall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check_output("sat_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
